stage_retire_fsm: RTL and testbench

Parametrised, stateful successor of the in-order retire stage. Each cycle it scans up to RETIRE_W lanes of the ROB head window and retires them in order, stopping at the first incomplete, mispredicted, store-blocked or halt lane. It sequences multi-cycle mispredict recovery, a store-commit handshake with the store queue, and a sticky halt. Architected-map and freelist updates are registered, one cycle behind the ROB pop.

---
 rtl/stage_retire_fsm.sv | 262 ++++++++++++++++++++++++++
 tb/tb_stage_retire_fsm.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_retire_fsm.sv
// stage_retire_fsm: multi-lane in-order retire stage with multi-cycle mispredict
// recovery, a one-store-per-cycle commit handshake and a sticky halt.
// Optional feature macro: RETIRE_PERF_EN adds retired_cnt / mispred_cnt counters.

package stage_retire_fsm_pkg;

  localparam int unsigned ROB_HEAD_N       = 4;
  localparam int unsigned PHYS_REG_SZ_R10K = 64;
  localparam int unsigned ROB_SZ           = 32;
  localparam int unsigned ARCH_REGS        = 32;
  localparam int unsigned XLEN             = 32;

  localparam int unsigned ROB_IDX_W  = $clog2(ROB_SZ);
  localparam int unsigned REG_IDX_W  = $clog2(ARCH_REGS);
  localparam int unsigned PHYS_TAG_W = $clog2(PHYS_REG_SZ_R10K);

  typedef logic [ROB_IDX_W-1:0]  ROB_IDX;
  typedef logic [REG_IDX_W-1:0]  REG_IDX;
  typedef logic [PHYS_TAG_W-1:0] PHYS_TAG;

  // One ROB slot as seen by retire.
  typedef struct packed {
    logic            complete;
    logic            branch;
    logic            pred_taken;
    logic            branch_taken;
    logic [XLEN-1:0] pred_target;
    logic [XLEN-1:0] branch_target;
    REG_IDX          arch_rd;
    PHYS_TAG         phys_rd;
    PHYS_TAG         prev_phys_rd;
  } ROB_ENTRY;

endpackage

module stage_retire_fsm
  import stage_retire_fsm_pkg::*;
#(
  parameter int unsigned N              = ROB_HEAD_N,
  parameter int unsigned RETIRE_W       = N,
  parameter int unsigned PHYS_REGS      = PHYS_REG_SZ_R10K,
  parameter int unsigned RECOVER_CYCLES = 2,
  parameter int unsigned CNT_W          = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  ROB_ENTRY [N-1:0]        head_entries,
  input  logic [N-1:0]            head_valids,
  input  ROB_IDX [N-1:0]          head_idxs,
  input  logic [N-1:0]            head_is_store,
  input  logic [N-1:0]            head_is_halt,
  output logic [$clog2(N+1)-1:0]  retire_count,
  output logic                    rob_mispredict,
  output ROB_IDX                  rob_mispred_idx,
  output logic                    bp_recover_en,
  output logic                    sq_commit_valid,
  output ROB_IDX                  sq_commit_idx,
  input  logic                    sq_commit_ready,
  output logic [PHYS_REGS-1:0]    free_mask,
  output logic [N-1:0]            arch_write_enables,
  output REG_IDX [N-1:0]          arch_write_addrs,
  output PHYS_TAG [N-1:0]         arch_write_phys_regs,
`ifdef RETIRE_PERF_EN
  output logic [CNT_W-1:0]        retired_cnt,
  output logic [CNT_W-1:0]        mispred_cnt,
`endif
  output logic                    recovering,
  output logic                    halted
);

  localparam int unsigned CW  = $clog2(N + 1);
  localparam int unsigned RCW = $clog2(RECOVER_CYCLES + 1);

  // Reject configurations the scan and recovery counter cannot support.
  if (RETIRE_W < 1 || RETIRE_W > N || RECOVER_CYCLES < 1 || CNT_W < 1) begin : g_bad_params
    $error("stage_retire_fsm: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_RECOVER = 2'd1,
    ST_HALTED  = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [RCW-1:0] rcnt_q, rcnt_d;

  logic [N-1:0]   ret_mask;
  logic [CW-1:0]  cnt_c;
  logic           mp_c;
  ROB_IDX         mp_idx_c;
  logic           sqv_c;
  ROB_IDX         sqi_c;
  logic           halt_c;
  logic           stop;
  logic           store_seen;
  ROB_ENTRY       cur;

  logic [N-1:0]          we_d, we_q;
  REG_IDX [N-1:0]        wa_d, wa_q;
  PHYS_TAG [N-1:0]       wp_d, wp_q;
  logic [PHYS_REGS-1:0]  free_d, free_q;
  logic                  shadowed;

  function automatic logic is_mispred(input ROB_ENTRY e);
    return e.branch && ((e.pred_taken != e.branch_taken) ||
                        (e.branch_taken && (e.pred_target != e.branch_target)));
  endfunction

  // Oldest-first scan of the eligible lanes; decides which lanes pop this edge.
  always_comb begin
    ret_mask   = '0;
    cnt_c      = '0;
    mp_c       = 1'b0;
    mp_idx_c   = '0;
    sqv_c      = 1'b0;
    sqi_c      = '0;
    halt_c     = 1'b0;
    stop       = 1'b0;
    store_seen = 1'b0;
    cur        = '0;
    if (state_q == ST_RUN) begin
      for (int unsigned i = 0; i < RETIRE_W; i++) begin
        if (!stop) begin
          cur = head_entries[N-1-i];
          if (!head_valids[N-1-i] || !cur.complete) begin
            stop = 1'b1;
          end else if (head_is_store[N-1-i]) begin
            // At most one store per group; it always ends the scan.
            stop = 1'b1;
            if (!store_seen) begin
              store_seen = 1'b1;
              sqv_c      = 1'b1;
              sqi_c      = head_idxs[N-1-i];
              if (sq_commit_ready) begin
                ret_mask[N-1-i] = 1'b1;
                cnt_c           = cnt_c + CW'(1);
              end
            end
          end else begin
            ret_mask[N-1-i] = 1'b1;
            cnt_c           = cnt_c + CW'(1);
            if (head_is_halt[N-1-i]) begin
              halt_c = 1'b1;
              stop   = 1'b1;
            end else if (is_mispred(cur)) begin
              mp_c     = 1'b1;
              mp_idx_c = head_idxs[N-1-i];
              stop     = 1'b1;
            end
          end
        end
      end
    end
  end

  // Arch-map writes (youngest writer of each arch_rd wins) and Told frees.
  always_comb begin
    we_d     = '0;
    wa_d     = '0;
    wp_d     = '0;
    free_d   = '0;
    shadowed = 1'b0;
    for (int unsigned w = 0; w < N; w++) begin
      if (ret_mask[w] && (head_entries[w].arch_rd != '0)) begin
        shadowed = 1'b0;
        for (int unsigned j = 0; j < w; j++) begin
          if (ret_mask[j] && (head_entries[j].arch_rd == head_entries[w].arch_rd)) begin
            shadowed = 1'b1;
          end
        end
        if (!shadowed) begin
          we_d[w] = 1'b1;
          wa_d[w] = head_entries[w].arch_rd;
          wp_d[w] = head_entries[w].phys_rd;
        end
        if ((head_entries[w].prev_phys_rd != '0) &&
            (32'(head_entries[w].prev_phys_rd) < PHYS_REGS)) begin
          free_d[head_entries[w].prev_phys_rd] = 1'b1;
        end
      end
    end
  end

  // Next-state logic: RUN -> HALTED on halt, RUN -> RECOVER on mispredict.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    case (state_q)
      ST_RUN: begin
        if (halt_c) begin
          state_d = ST_HALTED;
        end else if (mp_c) begin
          state_d = ST_RECOVER;
          rcnt_d  = RCW'(RECOVER_CYCLES);
        end
      end
      ST_RECOVER: begin
        rcnt_d = rcnt_q - RCW'(1);
        if (rcnt_d == '0) begin
          state_d = ST_RUN;
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      default: begin
        state_d = ST_RUN;
        rcnt_d  = '0;
      end
    endcase
  end

  // State and registered writeback outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      rcnt_q  <= '0;
      we_q    <= '0;
      wa_q    <= '0;
      wp_q    <= '0;
      free_q  <= '0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      we_q    <= we_d;
      wa_q    <= wa_d;
      wp_q    <= wp_d;
      free_q  <= free_d;
    end
  end

`ifdef RETIRE_PERF_EN
  logic [CNT_W-1:0] retired_cnt_q, mispred_cnt_q;

  // Free-running, wrapping performance counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      retired_cnt_q <= '0;
      mispred_cnt_q <= '0;
    end else begin
      retired_cnt_q <= retired_cnt_q + CNT_W'(cnt_c);
      mispred_cnt_q <= mispred_cnt_q + CNT_W'(mp_c);
    end
  end

  assign retired_cnt = retired_cnt_q;
  assign mispred_cnt = mispred_cnt_q;
`endif

  assign retire_count         = cnt_c;
  assign rob_mispredict       = mp_c;
  assign rob_mispred_idx      = mp_idx_c;
  assign bp_recover_en        = mp_c;
  assign sq_commit_valid      = sqv_c;
  assign sq_commit_idx        = sqi_c;
  assign free_mask            = free_q;
  assign arch_write_enables   = we_q;
  assign arch_write_addrs     = wa_q;
  assign arch_write_phys_regs = wp_q;
  assign recovering           = (state_q == ST_RECOVER);
  assign halted               = (state_q == ST_HALTED);

endmodule

// File: tb/tb_stage_retire_fsm.sv
// Bench for stage_retire_fsm: directed test-plan steps followed by random lanes,
// all checked against a list-based reference model of the retire rules.
module tb_stage_retire_fsm;
  import stage_retire_fsm_pkg::*;

  localparam int unsigned N     = 4;
  localparam int unsigned RW    = 4;
  localparam int unsigned PR    = PHYS_REG_SZ_R10K;
  localparam int unsigned RC    = 2;
  localparam int unsigned CNT_W = 32;
  localparam int unsigned CW    = $clog2(N + 1);

  logic             clock = 1'b0;
  logic             reset;
  ROB_ENTRY [N-1:0] head_entries;
  logic [N-1:0]     head_valids;
  ROB_IDX [N-1:0]   head_idxs;
  logic [N-1:0]     head_is_store;
  logic [N-1:0]     head_is_halt;
  logic [CW-1:0]    retire_count;
  logic             rob_mispredict;
  ROB_IDX           rob_mispred_idx;
  logic             bp_recover_en;
  logic             sq_commit_valid;
  ROB_IDX           sq_commit_idx;
  logic             sq_commit_ready;
  logic [PR-1:0]    free_mask;
  logic [N-1:0]     arch_write_enables;
  REG_IDX [N-1:0]   arch_write_addrs;
  PHYS_TAG [N-1:0]  arch_write_phys_regs;
  logic             recovering;
  logic             halted;
`ifdef RETIRE_PERF_EN
  logic [CNT_W-1:0] retired_cnt;
  logic [CNT_W-1:0] mispred_cnt;
`endif

  stage_retire_fsm #(
    .N(N), .RETIRE_W(RW), .PHYS_REGS(PR), .RECOVER_CYCLES(RC), .CNT_W(CNT_W)
  ) dut (
    .clock                (clock),
    .reset                (reset),
    .head_entries         (head_entries),
    .head_valids          (head_valids),
    .head_idxs            (head_idxs),
    .head_is_store        (head_is_store),
    .head_is_halt         (head_is_halt),
    .retire_count         (retire_count),
    .rob_mispredict       (rob_mispredict),
    .rob_mispred_idx      (rob_mispred_idx),
    .bp_recover_en        (bp_recover_en),
    .sq_commit_valid      (sq_commit_valid),
    .sq_commit_idx        (sq_commit_idx),
    .sq_commit_ready      (sq_commit_ready),
    .free_mask            (free_mask),
    .arch_write_enables   (arch_write_enables),
    .arch_write_addrs     (arch_write_addrs),
    .arch_write_phys_regs (arch_write_phys_regs),
`ifdef RETIRE_PERF_EN
    .retired_cnt          (retired_cnt),
    .mispred_cnt          (mispred_cnt),
`endif
    .recovering           (recovering),
    .halted               (halted)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int              m_rec_left;
  bit              m_halted;
  logic [N-1:0]    x_we;
  REG_IDX [N-1:0]  x_wa;
  PHYS_TAG [N-1:0] x_wp;
  logic [PR-1:0]   x_free;
  longint unsigned x_ret;
  longint unsigned x_mp;

  // Values observed in the most recent cycle, for directed follow-up checks.
  int     obs_cnt;
  logic   obs_mp;
  ROB_IDX obs_mpi;
  ROB_IDX obs_sqi;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit mispred_rule(input ROB_ENTRY e);
    if (!e.branch) return 1'b0;
    if (e.pred_taken != e.branch_taken) return 1'b1;
    return e.branch_taken && (e.pred_target != e.branch_target);
  endfunction

  task automatic model_reset();
    m_rec_left = 0;
    m_halted   = 1'b0;
    x_we       = '0;
    x_wa       = '0;
    x_wp       = '0;
    x_free     = '0;
    x_ret      = 0;
    x_mp       = 0;
  endtask

  task automatic clear_lanes();
    head_entries  = '0;
    head_valids   = '0;
    head_idxs     = '0;
    head_is_store = '0;
    head_is_halt  = '0;
  endtask

  task automatic set_lane(input int l, input int rd, input int phys, input int prev);
    head_valids[l]               = 1'b1;
    head_entries[l].complete     = 1'b1;
    head_entries[l].arch_rd      = REG_IDX'(rd);
    head_entries[l].phys_rd      = PHYS_TAG'(phys);
    head_entries[l].prev_phys_rd = PHYS_TAG'(prev);
    head_idxs[l]                 = ROB_IDX'(l + 8);
  endtask

  // One clock cycle: called at a falling edge with inputs already applied.
  task automatic cycle();
    int              retired[$];
    int              owner[ARCH_REGS];
    bit              e_halt, e_mp, e_sqv;
    ROB_IDX          e_mpi, e_sqi;
    int              l;
    ROB_ENTRY        e;
    logic [N-1:0]    n_we;
    REG_IDX [N-1:0]  n_wa;
    PHYS_TAG [N-1:0] n_wp;
    logic [PR-1:0]   n_free;
    #1;
    e_halt = 1'b0; e_mp = 1'b0; e_sqv = 1'b0; e_mpi = '0; e_sqi = '0;
    if (!m_halted && m_rec_left == 0) begin
      for (int k = 0; k < int'(RW); k++) begin
        l = int'(N) - 1 - k;
        e = head_entries[l];
        if (!head_valids[l] || !e.complete) break;
        if (head_is_store[l]) begin
          e_sqv = 1'b1;
          e_sqi = head_idxs[l];
          if (sq_commit_ready) retired.push_back(l);
          break;
        end
        retired.push_back(l);
        if (head_is_halt[l]) begin e_halt = 1'b1; break; end
        if (mispred_rule(e)) begin e_mp = 1'b1; e_mpi = head_idxs[l]; break; end
      end
    end
    obs_cnt = int'(retire_count);
    obs_mp  = rob_mispredict;
    obs_mpi = rob_mispred_idx;
    obs_sqi = sq_commit_idx;
    chk("retire_count", 128'(retire_count), 128'(retired.size()));
    chk("rob_mispredict", 128'(rob_mispredict), 128'(e_mp));
    chk("bp_recover_en", 128'(bp_recover_en), 128'(e_mp));
    if (e_mp) chk("rob_mispred_idx", 128'(rob_mispred_idx), 128'(e_mpi));
    chk("sq_commit_valid", 128'(sq_commit_valid), 128'(e_sqv));
    if (e_sqv) chk("sq_commit_idx", 128'(sq_commit_idx), 128'(e_sqi));
    chk("arch_write_enables", 128'(arch_write_enables), 128'(x_we));
    chk("arch_write_addrs", 128'(arch_write_addrs), 128'(x_wa));
    chk("arch_write_phys_regs", 128'(arch_write_phys_regs), 128'(x_wp));
    chk("free_mask", 128'(free_mask), 128'(x_free));
    chk("recovering", 128'(recovering), 128'(m_rec_left > 0));
    chk("halted", 128'(halted), 128'(m_halted));
`ifdef RETIRE_PERF_EN
    chk("retired_cnt", 128'(retired_cnt), 128'(CNT_W'(x_ret)));
    chk("mispred_cnt", 128'(mispred_cnt), 128'(CNT_W'(x_mp)));
`endif
    // Last retiring writer of each arch register (youngest) owns the write.
    foreach (owner[r]) owner[r] = -1;
    foreach (retired[q]) owner[head_entries[retired[q]].arch_rd] = retired[q];
    n_we = '0; n_wa = '0; n_wp = '0; n_free = '0;
    for (int r = 1; r < int'(ARCH_REGS); r++) begin
      if (owner[r] >= 0) begin
        n_we[owner[r]] = 1'b1;
        n_wa[owner[r]] = REG_IDX'(r);
        n_wp[owner[r]] = head_entries[owner[r]].phys_rd;
      end
    end
    foreach (retired[q]) begin
      e = head_entries[retired[q]];
      if (e.arch_rd != 0 && e.prev_phys_rd != 0 && int'(e.prev_phys_rd) < int'(PR))
        n_free[e.prev_phys_rd] = 1'b1;
    end
    x_ret += longint'(retired.size());
    x_mp  += longint'(e_mp);
    if (m_rec_left > 0) m_rec_left--;
    else if (e_halt) m_halted = 1'b1;
    else if (e_mp) m_rec_left = int'(RC);
    x_we = n_we; x_wa = n_wa; x_wp = n_wp; x_free = n_free;
    @(negedge clock);
  endtask

  // Asynchronous reset pulse started at a falling edge.
  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_recovering", 128'(recovering), 128'(0));
    chk("rst_halted", 128'(halted), 128'(0));
    chk("rst_enables", 128'(arch_write_enables), 128'(0));
    chk("rst_free_mask", 128'(free_mask), 128'(0));
`ifdef RETIRE_PERF_EN
    chk("rst_retired_cnt", 128'(retired_cnt), 128'(0));
    chk("rst_mispred_cnt", 128'(mispred_cnt), 128'(0));
`endif
    model_reset();
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic random_lanes();
    ROB_ENTRY e;
    for (int l = 0; l < int'(N); l++) begin
      e               = '0;
      e.complete      = ($urandom_range(0, 99) < 85);
      e.branch        = ($urandom_range(0, 3) == 0);
      e.pred_taken    = 1'($urandom);
      e.branch_taken  = 1'($urandom);
      e.pred_target   = $urandom;
      e.branch_target = ($urandom_range(0, 9) < 7) ? e.pred_target : $urandom;
      e.arch_rd       = REG_IDX'($urandom_range(0, 7));
      e.phys_rd       = PHYS_TAG'($urandom);
      e.prev_phys_rd  = PHYS_TAG'($urandom);
      head_entries[l] = e;
      head_valids[l]  = ($urandom_range(0, 99) < 90);
      head_idxs[l]    = ROB_IDX'($urandom);
      head_is_store[l] = ($urandom_range(0, 99) < 20);
      head_is_halt[l]  = !head_is_store[l] && ($urandom_range(0, 99) < 3);
    end
  endtask

  initial begin
    reset = 1'b0;
    sq_commit_ready = 1'b0;
    clear_lanes();
    model_reset();
    @(negedge clock);
    chk("reset_retire_count", 128'(retire_count), 128'(0));
    chk("reset_free_mask", 128'(free_mask), 128'(0));
    chk("reset_enables", 128'(arch_write_enables), 128'(0));
    chk("reset_recovering", 128'(recovering), 128'(0));
    chk("reset_halted", 128'(halted), 128'(0));
    reset = 1'b1;
    @(negedge clock);

    // Four plain retires: arch_rd 1..4, Told 10..13.
    clear_lanes();
    sq_commit_ready = 1'b1;
    for (int l = 0; l < 4; l++) set_lane(l, 4 - l, 30 + l, 13 - l);
    cycle();
    chk("tp1_count", 128'(obs_cnt), 128'(4));
    chk("tp1_enables", 128'(arch_write_enables), 128'(4'b1111));
    chk("tp1_free", 128'(free_mask), 128'(64'h0000_0000_0000_3C00));
    clear_lanes();
    cycle();

    // Mispredict in lane 2 after a plain lane 3.
    clear_lanes();
    for (int l = 0; l < 4; l++) set_lane(l, l + 1, 40 + l, 0);
    head_entries[2].branch       = 1'b1;
    head_entries[2].pred_taken   = 1'b0;
    head_entries[2].branch_taken = 1'b1;
    cycle();
    chk("tp2_count", 128'(obs_cnt), 128'(2));
    chk("tp2_mispredict", 128'(obs_mp), 128'(1));
    chk("tp2_idx", 128'(obs_mpi), 128'(10));
    head_entries[2].branch = 1'b0;
    cycle();
    chk("tp2_stall1", 128'(obs_cnt), 128'(0));
    cycle();
    chk("tp2_stall2", 128'(obs_cnt), 128'(0));
    cycle();
    chk("tp2_resume", 128'(obs_cnt), 128'(4));

    // Two stores: the first waits for sq_commit_ready.
    clear_lanes();
    set_lane(3, 1, 5, 6);
    set_lane(2, 2, 7, 8);
    head_is_store[3] = 1'b1;
    head_is_store[2] = 1'b1;
    sq_commit_ready  = 1'b0;
    for (int c = 0; c < 3; c++) begin
      cycle();
      chk("tp3_blocked", 128'(obs_cnt), 128'(0));
      chk("tp3_sq_idx", 128'(obs_sqi), 128'(11));
    end
    sq_commit_ready = 1'b1;
    cycle();
    chk("tp3_commit", 128'(obs_cnt), 128'(1));

    // Lanes 3 and 1 share arch_rd 5.
    clear_lanes();
    set_lane(3, 5, 50, 20);
    set_lane(2, 0, 51, 21);
    set_lane(1, 5, 52, 22);
    set_lane(0, 0, 53, 23);
    cycle();
    chk("tp4_enables", 128'(arch_write_enables), 128'(4'b0010));
    chk("tp4_free", 128'(free_mask), 128'(64'h0000_0000_0050_0000));
    clear_lanes();
    cycle();

    // Halt in lane 2.
    clear_lanes();
    set_lane(3, 1, 2, 3);
    set_lane(2, 2, 4, 5);
    set_lane(1, 3, 6, 7);
    head_is_halt[2] = 1'b1;
    cycle();
    chk("tp5_count", 128'(obs_cnt), 128'(2));
    chk("tp5_halted", 128'(halted), 128'(1));
    for (int c = 0; c < 3; c++) begin
      cycle();
      chk("tp5_frozen", 128'(obs_cnt), 128'(0));
    end
    do_reset();

    // Reset while recovering.
    clear_lanes();
    set_lane(3, 4, 9, 9);
    head_entries[3].branch       = 1'b1;
    head_entries[3].pred_taken   = 1'b1;
    head_entries[3].branch_taken = 1'b1;
    head_entries[3].pred_target  = 32'h100;
    head_entries[3].branch_target = 32'h200;
    cycle();
    chk("tp6_recovering", 128'(recovering), 128'(1));
    clear_lanes();
    do_reset();

    // Random traffic.
    for (int c = 0; c < 2000; c++) begin
      random_lanes();
      sq_commit_ready = ($urandom_range(0, 99) < 60);
      cycle();
      if (m_halted && $urandom_range(0, 2) == 0) do_reset();
      else if (m_rec_left > 0 && $urandom_range(0, 19) == 0) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
